vga_motion_ctrl: RTL and testbench
==================================

Name: vga_motion_ctrl

Overview:
- Per-frame motion scheduler for the VGA shape renderer. Holds the live positions of the rectangle, circle and triangle, and moves each by a programmable step once per N frames during vertical blanking. Positions bounce off the 640x480 display edges.
- One shared bounce/step unit processes the three shapes sequentially. New positions are double-buffered and committed together, so the renderer never sees a mixed set inside a frame.

Parameters:
- H_DISPLAY, 640, visible width in pixels
- V_DISPLAY, 480, visible height in lines
- RECT_W / RECT_H, 150 / 100, rectangle size
- CIRC_R, 75, circle radius
- TRI_W / TRI_H, 150 / 100, triangle bounding-box size
- RECT_X0 / RECT_Y0, 100 / 100, rectangle top-left at reset and on home
- CIRC_X0 / CIRC_Y0, 400 / 150, circle centre at reset and on home
- TRI_X0 / TRI_Y0, 300 / 250, triangle bbox top-left at reset and on home
- STEP, 2, base step in pixels (1..15)
- FRAME_DIV, 1, update once every FRAME_DIV frames (1..255)

Ports:
- CLOCK_50  in  1  50 MHz system clock
- RESET_N  in  1  asynchronous active-low reset
- v_blank  in  1  vertical blank level from the timing generator; asynchronous, 2-FF synchronised internally
- run  in  1  enables motion (SW)
- speed  in  2  step multiplier select: step = STEP << speed
- home  in  1  single-cycle pulse requesting return to the initial positions
- rect_x, rect_y  out  10 each  committed rectangle top-left
- circ_x, circ_y  out  10 each  committed circle centre
- tri_x, tri_y  out  10 each  committed triangle bbox top-left
- busy  out  1  high in the CALC0..COMMIT states
- update_done  out  1  one-cycle pulse when new positions appear
- frame_cnt  out  16  count of v_blank rising edges, wraps at 65535 -> 0

Behaviour:
- Reset, asynchronous assert:
  - All outputs go to their initial-position parameters; busy=0, update_done=0, frame_cnt=0.
  - Directions: rect (+x,+y), circ (-x,+y), tri (+x,-y).
  - div_cnt=0, home_pend=0, synchroniser=0, state=IDLE.
- Edge detect: edge = sync_q & ~sync_qq. Every edge increments frame_cnt, including while busy.
- home pulse sets home_pend, which stays set until consumed at COMMIT.
- Bounds, per axis, with min..max inclusive:
  - rect x 0..H_DISPLAY-RECT_W, y 0..V_DISPLAY-RECT_H
  - circ x CIRC_R..H_DISPLAY-1-CIRC_R, y CIRC_R..V_DISPLAY-1-CIRC_R
  - tri x 0..H_DISPLAY-TRI_W, y 0..V_DISPLAY-TRI_H
- FSM: IDLE -> CALC0 (rect) -> CALC1 (circ) -> CALC2 (tri) -> COMMIT -> IDLE.
- IDLE, on edge:
  - If home_pend: go to CALC0 and set div_cnt=0. Home ignores run and FRAME_DIV.
  - Else if div_cnt==FRAME_DIV-1: set div_cnt=0 and go to CALC0 only if run=1.
  - Else: div_cnt+1.
- CALCn, computed per axis with 11-bit unsigned intermediates into shadow registers:
  - home_pend: pos=initial value, direction=reset direction.
  - Positive direction: if pos+step > max, then pos=max and the direction flips; else pos+=step.
  - Negative direction: if pos < min+step, then pos=min and the direction flips; else pos-=step.
- step and home_pend are sampled once, at CALC0, and held for the whole update.
- COMMIT: all six shadow registers are copied to the outputs on the same edge, and home_pend is cleared. A home pulse arriving during CALC0..COMMIT is kept pending for the next edge.
- Latency, with the edge detected at clock k:
  - CALC0 during k+1, COMMIT during k+4.
  - Outputs change at clock k+5, with update_done=1 during the k+5 cycle.
- Edges during busy are counted in frame_cnt only; div_cnt does not advance.
- run=0: positions freeze; div_cnt keeps counting.
- A speed change takes effect at the next CALC0.
- Reset mid-update: the async reset wins, the shadow result is discarded, and the outputs return to the initial values.

Test Plan:
- Reset -> rect 100/100, circ 400/150, tri 300/250, busy=0, frame_cnt=0.
- run=1, speed=0, one v_blank rise -> rect 102/102, circ 398/152, tri 302/248; update_done exactly 5 clocks after edge detect; busy high 4 cycles.
- RECT_X0=489, run=1, speed=0 -> after edge 1 rect_x=490 with x direction flipped; after edge 2 rect_x=488.
- FRAME_DIV=3, run=1, 6 edges -> positions change only on edges 3 and 6; frame_cnt=6.
- run=0, then home pulse after two moving updates -> next edge restores 100/100, 400/150, 300/250 with reset directions; home pending through a busy window is applied on the following edge.
- Assert RESET_N=0 during CALC1 -> outputs immediately return to the initial values and busy=0; no update_done pulse.

Source files
------------

// File: rtl/vga_motion_ctrl.sv
// Per-frame motion scheduler for the VGA shape renderer.
// One shared bounce/step unit updates rect, circ and tri in turn, and COMMIT publishes all six positions on one edge.
module vga_motion_ctrl #(
   parameter int H_DISPLAY = 640,
   parameter int V_DISPLAY = 480,
   parameter int RECT_W    = 150,
   parameter int RECT_H    = 100,
   parameter int CIRC_R    = 75,
   parameter int TRI_W     = 150,
   parameter int TRI_H     = 100,
   parameter int RECT_X0   = 100,
   parameter int RECT_Y0   = 100,
   parameter int CIRC_X0   = 400,
   parameter int CIRC_Y0   = 150,
   parameter int TRI_X0    = 300,
   parameter int TRI_Y0    = 250,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        v_blank,
   input  logic        run,
   input  logic [1:0]  speed,
   input  logic        home,
   output logic [9:0]  rect_x,
   output logic [9:0]  rect_y,
   output logic [9:0]  circ_x,
   output logic [9:0]  circ_y,
   output logic [9:0]  tri_x,
   output logic [9:0]  tri_y,
   output logic        busy,
   output logic        update_done,
   output logic [15:0] frame_cnt
);

   typedef enum logic [2:0] {IDLE, CALC0, CALC1, CALC2, COMMIT} state_t;

   // Index order for all per-axis tables: rect_x, rect_y, circ_x, circ_y, tri_x, tri_y.
   localparam logic [5:0][9:0] POS_INIT = {10'(TRI_Y0), 10'(TRI_X0), 10'(CIRC_Y0),
                                           10'(CIRC_X0), 10'(RECT_Y0), 10'(RECT_X0)};
   localparam logic [5:0][9:0] POS_MIN  = {10'd0, 10'd0, 10'(CIRC_R), 10'(CIRC_R), 10'd0, 10'd0};
   localparam logic [5:0][9:0] POS_MAX  = {10'(V_DISPLAY - TRI_H), 10'(H_DISPLAY - TRI_W),
                                           10'(V_DISPLAY - 1 - CIRC_R), 10'(H_DISPLAY - 1 - CIRC_R),
                                           10'(V_DISPLAY - RECT_H), 10'(H_DISPLAY - RECT_W)};
   localparam logic [5:0]      DIR_INIT  = 6'b011011;  // 1 = moving towards max
   localparam logic [7:0]      DIV_LAST  = 8'(FRAME_DIV - 1);
   localparam logic [6:0]      STEP_BASE = 7'(STEP);

   state_t           state_q, state_d;
   logic             sync_q, sync_qq, vb_rise;
   logic [7:0]       div_cnt_q, div_cnt_d;
   logic             home_pend_q, home_pend_d;
   logic             home_rearm_q, home_rearm_d;
   logic             home_lat_q;
   logic [6:0]       step_q;
   logic [5:0]       dir_q;
   logic [5:0][9:0]  pos_q, shd_q;
   logic             update_done_q;
   logic [15:0]      frame_cnt_q;
   logic             start, calc;
   logic [2:0]       ax, ay;
   logic [10:0]      res_x, res_y;

   // Returns {new_dir, new_pos}; 11-bit sums keep pos+step from wrapping.
   function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                          input logic [9:0] lo, input logic [9:0] hi,
                                          input logic [6:0] step);
      logic [10:0] sum, thr;
      sum = {1'b0, pos} + 11'(step);
      thr = {1'b0, lo} + 11'(step);
      if (dir) begin
         if (sum > {1'b0, hi}) return {1'b0, hi};
         else                  return {1'b1, sum[9:0]};
      end else begin
         if ({1'b0, pos} < thr) return {1'b1, lo};
         else                   return {1'b0, pos - 10'(step)};
      end
   endfunction

   assign vb_rise = sync_q & ~sync_qq;
   assign busy    = (state_q != IDLE);
   assign calc    = (state_q == CALC0) || (state_q == CALC1) || (state_q == CALC2);

   // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      start        = 1'b0;
      home_pend_d  = home_pend_q;
      home_rearm_d = home_rearm_q;
      unique case (state_q)
         IDLE: begin
            if (vb_rise) begin
               if (home_pend_q) begin
                  start     = 1'b1;
                  div_cnt_d = '0;
               end else if (div_cnt_q == DIV_LAST) begin
                  start     = run;
                  div_cnt_d = '0;
               end else begin
                  div_cnt_d = div_cnt_q + 8'd1;
               end
               if (start) state_d = CALC0;
            end
         end
         CALC0:   state_d = CALC1;
         CALC1:   state_d = CALC2;
         CALC2:   state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A pulse seen after the update latched home_pend must survive the clear at COMMIT.
      if (state_q == COMMIT) begin
         home_pend_d  = home_rearm_q;
         home_rearm_d = 1'b0;
      end
      if (home) begin
         home_pend_d = 1'b1;
         if (start || (busy && state_q != COMMIT)) home_rearm_d = 1'b1;
      end
   end

   always_comb begin
      unique case (state_q)
         CALC1:   ax = 3'd2;
         CALC2:   ax = 3'd4;
         default: ax = 3'd0;
      endcase
      ay    = ax + 3'd1;
      res_x = bounce(pos_q[ax], dir_q[ax], POS_MIN[ax], POS_MAX[ax], step_q);
      res_y = bounce(pos_q[ay], dir_q[ay], POS_MIN[ay], POS_MAX[ay], step_q);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         sync_q        <= 1'b0;
         sync_qq       <= 1'b0;
         div_cnt_q     <= '0;
         home_pend_q   <= 1'b0;
         home_rearm_q  <= 1'b0;
         home_lat_q    <= 1'b0;
         step_q        <= STEP_BASE;
         dir_q         <= DIR_INIT;
         pos_q         <= POS_INIT;
         shd_q         <= POS_INIT;
         update_done_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         sync_q        <= v_blank;
         sync_qq       <= sync_q;
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         home_pend_q   <= home_pend_d;
         home_rearm_q  <= home_rearm_d;
         update_done_q <= (state_q == COMMIT);
         if (vb_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (start) begin
            step_q     <= STEP_BASE << speed;
            home_lat_q <= home_pend_q;
         end
         if (calc) begin
            if (home_lat_q) begin
               shd_q[ax] <= POS_INIT[ax];
               shd_q[ay] <= POS_INIT[ay];
               dir_q[ax] <= DIR_INIT[ax];
               dir_q[ay] <= DIR_INIT[ay];
            end else begin
               shd_q[ax] <= res_x[9:0];
               shd_q[ay] <= res_y[9:0];
               dir_q[ax] <= res_x[10];
               dir_q[ay] <= res_y[10];
            end
         end
         if (state_q == COMMIT) pos_q <= shd_q;
      end
   end

   assign rect_x      = pos_q[0];
   assign rect_y      = pos_q[1];
   assign circ_x      = pos_q[2];
   assign circ_y      = pos_q[3];
   assign tri_x       = pos_q[4];
   assign tri_y       = pos_q[5];
   assign update_done = update_done_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_motion_ctrl.sv
// Bench for vga_motion_ctrl: three parameterisations share one stimulus stream.
// Each instance is compared against a frame-level model of positions, directions and counters.
module tb_vga_motion_ctrl;

   logic CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   logic        RESET_N, v_blank, run, home;
   logic [1:0]  speed;
   logic [9:0]  obs    [3][6];
   logic [15:0] fcnt   [3];
   logic        busy_w [3];
   logic        ud_w   [3];

   vga_motion_ctrl u_a (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .v_blank(v_blank), .run(run), .speed(speed), .home(home),
      .rect_x(obs[0][0]), .rect_y(obs[0][1]), .circ_x(obs[0][2]), .circ_y(obs[0][3]),
      .tri_x(obs[0][4]), .tri_y(obs[0][5]), .busy(busy_w[0]), .update_done(ud_w[0]), .frame_cnt(fcnt[0]));

   vga_motion_ctrl #(.RECT_X0(489)) u_b (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .v_blank(v_blank), .run(run), .speed(speed), .home(home),
      .rect_x(obs[1][0]), .rect_y(obs[1][1]), .circ_x(obs[1][2]), .circ_y(obs[1][3]),
      .tri_x(obs[1][4]), .tri_y(obs[1][5]), .busy(busy_w[1]), .update_done(ud_w[1]), .frame_cnt(fcnt[1]));

   vga_motion_ctrl #(.FRAME_DIV(3)) u_c (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .v_blank(v_blank), .run(run), .speed(speed), .home(home),
      .rect_x(obs[2][0]), .rect_y(obs[2][1]), .circ_x(obs[2][2]), .circ_y(obs[2][3]),
      .tri_x(obs[2][4]), .tri_y(obs[2][5]), .busy(busy_w[2]), .update_done(ud_w[2]), .frame_cnt(fcnt[2]));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, per instance and per axis (rect_x, rect_y, circ_x, circ_y, tri_x, tri_y).
   int m_pos [3][6];
   int m_dir [3][6];
   int m_div [3];
   bit m_home[3];
   int m_fc  [3];
   int init_tab [3][6] = '{'{100, 100, 400, 150, 300, 250},
                           '{489, 100, 400, 150, 300, 250},
                           '{100, 100, 400, 150, 300, 250}};
   int fd_tab [3] = '{1, 1, 3};
   int lo_tab [6] = '{0, 0, 75, 75, 0, 0};
   int hi_tab [6] = '{490, 380, 564, 404, 490, 380};
   int dir0   [6] = '{1, 1, -1, 1, 1, -1};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 6; k++) begin
            m_pos[i][k] = init_tab[i][k];
            m_dir[i][k] = dir0[k];
         end
         m_div[i]  = 0;
         m_home[i] = 1'b0;
         m_fc[i]   = 0;
      end
   endfunction

   // One v_blank rise seen by an idle instance; returns 1 when an update is started.
   function automatic bit model_edge(input int i);
      int st;
      st = 2 << speed;
      m_fc[i] = (m_fc[i] + 1) % 65536;
      if (m_home[i]) begin
         for (int k = 0; k < 6; k++) begin
            m_pos[i][k] = init_tab[i][k];
            m_dir[i][k] = dir0[k];
         end
         m_div[i]  = 0;
         m_home[i] = 1'b0;
         return 1'b1;
      end
      if (m_div[i] == fd_tab[i] - 1) begin
         m_div[i] = 0;
         if (!run) return 1'b0;
         for (int k = 0; k < 6; k++) begin
            if (m_dir[i][k] > 0) begin
               if (m_pos[i][k] + st > hi_tab[k]) begin
                  m_pos[i][k] = hi_tab[k];
                  m_dir[i][k] = -1;
               end else m_pos[i][k] += st;
            end else begin
               if (m_pos[i][k] < lo_tab[k] + st) begin
                  m_pos[i][k] = lo_tab[k];
                  m_dir[i][k] = 1;
               end else m_pos[i][k] -= st;
            end
         end
         return 1'b1;
      end
      m_div[i]++;
      return 1'b0;
   endfunction

   // Model of one vb_cycle: first edge, optional home at cycle 3, optional second edge, optional home at cycle 8.
   function automatic void model_cycle(input int home_at, input int reedge_at);
      bit started [3];
      for (int i = 0; i < 3; i++) started[i] = model_edge(i);
      if (home_at == 3) for (int i = 0; i < 3; i++) m_home[i] = 1'b1;
      if (reedge_at > 0) begin
         for (int i = 0; i < 3; i++) begin
            if (started[i]) m_fc[i] = (m_fc[i] + 1) % 65536;
            else            void'(model_edge(i));
         end
      end
      if (home_at == 8) for (int i = 0; i < 3; i++) m_home[i] = 1'b1;
   endfunction

   // Fixed 14-cycle window starting at a falling clock edge; reports when instance A pulsed update_done.
   task automatic vb_cycle(input int home_at, input int reedge_at, output int ud_at, output int busy_n);
      ud_at  = -1;
      busy_n = 0;
      v_blank = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLOCK_50);
         if (busy_w[0]) busy_n++;
         if (ud_w[0]) ud_at = (ud_at < 0) ? c : 99;
         v_blank = (c < 2) || (reedge_at > 0 && c >= reedge_at && c < reedge_at + 2);
         home    = (c == home_at);
      end
      v_blank = 1'b0;
      home    = 1'b0;
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 6; k++)
            check($sformatf("%s dut%0d axis%0d", tag, i, k), 32'(obs[i][k]), 32'(m_pos[i][k]));
         check($sformatf("%s dut%0d frame_cnt", tag, i), 32'(fcnt[i]), 32'(m_fc[i]));
      end
   endtask

   initial begin
      int ud_at, busy_n, prev_c, hsel, rsel, ud_seen;
      RESET_N = 1'b0; v_blank = 1'b0; run = 1'b0; home = 1'b0; speed = 2'd0;
      model_reset();
      repeat (2) @(negedge CLOCK_50);
      check("reset rect_x", 32'(obs[0][0]), 100);
      check("reset circ_x", 32'(obs[0][2]), 400);
      check("reset tri_y",  32'(obs[0][5]), 250);
      check("reset busy",   32'(busy_w[0]), 0);
      check("reset frame_cnt", 32'(fcnt[0]), 0);
      compare_all("reset");
      RESET_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      // Edge 1: basic move, latency and busy width.
      run = 1'b1;
      vb_cycle(0, 0, ud_at, busy_n);
      model_cycle(0, 0);
      check("update_done cycle", ud_at, 6);
      check("busy width", busy_n, 4);
      check("move rect_x", 32'(obs[0][0]), 102);
      check("move rect_y", 32'(obs[0][1]), 102);
      check("move circ_x", 32'(obs[0][2]), 398);
      check("move circ_y", 32'(obs[0][3]), 152);
      check("move tri_x",  32'(obs[0][4]), 302);
      check("move tri_y",  32'(obs[0][5]), 248);
      check("bounce edge1 rect_x", 32'(obs[1][0]), 490);
      check("div3 edge1 rect_x",   32'(obs[2][0]), 100);
      compare_all("edge1");

      // Edge 2: reflected axis moves back down.
      vb_cycle(0, 0, ud_at, busy_n);
      model_cycle(0, 0);
      check("bounce edge2 rect_x", 32'(obs[1][0]), 488);
      check("div3 edge2 rect_x",   32'(obs[2][0]), 100);
      compare_all("edge2");

      // Edges 3..6: divided instance moves on every third edge only.
      for (int e = 3; e <= 6; e++) begin
         prev_c = obs[2][0];
         vb_cycle(0, 0, ud_at, busy_n);
         model_cycle(0, 0);
         check($sformatf("div3 moved edge%0d", e), 32'(obs[2][0] != prev_c), 32'(e % 3 == 0));
         compare_all("div3");
      end
      check("div3 frame_cnt", 32'(fcnt[2]), 6);

      // Home while idle with run low.
      run = 1'b0;
      home = 1'b1;
      @(negedge CLOCK_50);
      home = 1'b0;
      @(negedge CLOCK_50);
      for (int i = 0; i < 3; i++) m_home[i] = 1'b1;
      vb_cycle(0, 0, ud_at, busy_n);
      model_cycle(0, 0);
      check("home rect_x", 32'(obs[0][0]), 100);
      check("home circ_y", 32'(obs[0][3]), 150);
      check("home tri_x",  32'(obs[0][4]), 300);
      compare_all("home");

      // Home arriving during a busy window is applied on the following edge.
      run = 1'b1;
      vb_cycle(3, 0, ud_at, busy_n);
      model_cycle(3, 0);
      check("home busy moved rect_x", 32'(obs[0][0]), 102);
      compare_all("home busy1");
      run = 1'b0;
      vb_cycle(0, 0, ud_at, busy_n);
      model_cycle(0, 0);
      check("home busy restored rect_x", 32'(obs[0][0]), 100);
      compare_all("home busy2");

      // Edge during busy: counted, not processed.
      run = 1'b1;
      vb_cycle(0, 4, ud_at, busy_n);
      model_cycle(0, 4);
      check("busy edge single update", ud_at, 6);
      compare_all("busy edge");

      // Randomized frames.
      for (int it = 0; it < 40; it++) begin
         run   = ($urandom_range(0, 3) != 0);
         speed = 2'($urandom_range(0, 3));
         hsel  = $urandom_range(0, 5);
         rsel  = ($urandom_range(0, 3) == 0) ? 4 : 0;
         hsel  = (hsel == 0) ? 3 : (hsel == 1) ? 8 : 0;
         vb_cycle(hsel, rsel, ud_at, busy_n);
         model_cycle(hsel, rsel);
         compare_all($sformatf("rand%0d", it));
      end

      // Let any pending home be consumed, then reset in the middle of an update.
      run = 1'b0;
      vb_cycle(0, 0, ud_at, busy_n);
      model_cycle(0, 0);
      compare_all("pre reset");
      run = 1'b1;
      speed = 2'd1;
      v_blank = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      check("busy before reset", 32'(busy_w[0]), 1);
      RESET_N = 1'b0;
      v_blank = 1'b0;
      #1;
      model_reset();
      check("midreset rect_x", 32'(obs[0][0]), 100);
      check("midreset circ_x", 32'(obs[0][2]), 400);
      check("midreset busy",   32'(busy_w[0]), 0);
      compare_all("midreset");
      repeat (2) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      ud_seen = 0;
      repeat (10) begin
         @(negedge CLOCK_50);
         if (ud_w[0]) ud_seen++;
      end
      check("no update_done after reset", ud_seen, 0);
      compare_all("post reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
